// File: rtl/packet_receiver.sv
// -----------------------------------------------------------------------------
// packet_receiver
//
// Byte-stream packet decoder sitting behind a UART receiver. It frames packets
// of the form  SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK  where CHK is the
// 8-bit modulo-256 sum of CMD, LEN and every payload byte. Good packets are
// published on pkt_cmd/pkt_len/pkt_data with a one-cycle pkt_valid pulse. Bad
// packets raise a one-cycle pkt_err pulse, and pkt_err_code records the cause.
//
// Optional feature macro: RX_TIMEOUT_EN
//   When defined, a partial packet is abandoned with error code 11 after
//   TIMEOUT_CYCLES consecutive cycles without a byte strobe. When it is not
//   defined, a partial packet waits indefinitely and no counter is built.
//
// Parameters
//   SYNC_BYTE      start-of-packet marker
//   MAX_LEN        largest accepted payload length (1..8)
//   TIMEOUT_CYCLES inter-byte timeout in clk cycles (RX_TIMEOUT_EN only)
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   rx_data      in   received byte, valid when new_rx_data is high
//   new_rx_data  in   one-cycle byte strobe
//   pkt_cmd      out  command byte of the last good packet
//   pkt_len      out  payload length of the last good packet
//   pkt_data     out  payload, byte i in bits [8i+7:8i], unused bytes zero
//   pkt_valid    out  one-cycle pulse: good packet published
//   pkt_err      out  one-cycle pulse: packet discarded
//   pkt_err_code out  cause of last error: 01 length, 10 checksum, 11 timeout
// -----------------------------------------------------------------------------
module packet_receiver #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic [7:0]  pkt_cmd,
  output logic [3:0]  pkt_len,
  output logic [63:0] pkt_data,
  output logic        pkt_valid,
  output logic        pkt_err,
  output logic [1:0]  pkt_err_code
);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_PAYLOAD,
    GET_CHK
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t      state;
  logic [7:0]  chk_sum;   // running checksum of CMD, LEN and payload
  logic [3:0]  idx;       // next payload byte position
  logic [7:0]  cmd_q;     // CMD of the packet being received
  logic [3:0]  len_q;     // LEN of the packet being received
  logic [63:0] buf_q;     // payload staging; copied out only on a good CHK
  logic        timeout;   // partial packet has gone silent too long

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // Counts silent cycles while a packet is in progress. Any strobe restarts
  // the count, and sitting in IDLE keeps it parked at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (new_rx_data || state == IDLE || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A strobe in the expiry cycle wins: the byte is processed instead.
  assign timeout = !new_rx_data && state != IDLE &&
                   tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // NOTE: every register here is updated with <= so all reads in this block
  // see the pre-edge values; a blocking '=' would let the new checksum leak
  // into the CHK compare of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      chk_sum      <= '0;
      idx          <= '0;
      cmd_q        <= '0;
      len_q        <= '0;
      // NOTE: the payload buffer is reset too; it is a plain 64-bit register,
      // not a RAM, and a zeroed buffer is what makes unused bytes read as zero.
      buf_q        <= '0;
      pkt_cmd      <= '0;
      pkt_len      <= '0;
      pkt_data     <= '0;
      pkt_valid    <= 1'b0;
      pkt_err      <= 1'b0;
      pkt_err_code <= 2'b00;
    end else begin
      // Both pulses default low so each lasts exactly one cycle.
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;

      if (new_rx_data) begin
        case (state)
          IDLE: begin
            // Anything other than the marker is line noise and is dropped.
            if (rx_data == SYNC_BYTE) begin
              buf_q <= '0;
              state <= GET_CMD;
            end
          end

          GET_CMD: begin
            cmd_q   <= rx_data;
            chk_sum <= rx_data;
            state   <= GET_LEN;
          end

          GET_LEN: begin
            if (rx_data > 8'(MAX_LEN)) begin
              pkt_err      <= 1'b1;
              pkt_err_code <= ERR_LEN;
              state        <= IDLE;
            end else begin
              len_q   <= rx_data[3:0];
              chk_sum <= chk_sum + rx_data;
              idx     <= '0;
              state   <= (rx_data == 8'd0) ? GET_CHK : GET_PAYLOAD;
            end
          end

          GET_PAYLOAD: begin
            buf_q[{idx[2:0], 3'b000} +: 8] <= rx_data;
            chk_sum <= chk_sum + rx_data;
            idx     <= idx + 4'd1;
            if (idx == len_q - 4'd1) begin
              state <= GET_CHK;
            end
          end

          GET_CHK: begin
            if (rx_data == chk_sum) begin
              pkt_valid <= 1'b1;
              pkt_cmd   <= cmd_q;
              pkt_len   <= len_q;
              pkt_data  <= buf_q;
            end else begin
              pkt_err      <= 1'b1;
              pkt_err_code <= ERR_CHK;
            end
            state <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        pkt_err      <= 1'b1;
        pkt_err_code <= ERR_TIMEOUT;
        state        <= IDLE;
      end
    end
  end

endmodule
